// File: rtl/wb_fsm_burst_pkg.sv
// wb_fsm_burst_pkg: shared encodings and burst-length decode for the burst port FSM
package wb_fsm_burst_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LIN     = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR       = 2'd1;
  localparam logic [1:0] ST_RD       = 2'd2;
  localparam logic [1:0] ST_FE       = 2'd3;
  // Beats in a burst; 0 marks an open-ended linear burst, unknown cycle types act as classic
  function automatic logic [4:0] decode_len(input logic [2:0] cti, input logic [1:0] bte);
    return cti != CTI_INC ? 5'd1 :
           bte == BTE_WRAP4 ? 5'd4 :
           bte == BTE_WRAP8 ? 5'd8 :
           bte == BTE_WRAP16 ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/wb_ack_delay.sv
// wb_ack_delay: fixed-depth shift register aligning read acks with read-data latency
module wb_ack_delay #(
  parameter int DEPTH = 1
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o,
  output logic empty_o
);
  logic [DEPTH-1:0] sr_q, sr_d;
  assign sr_d = clr_i ? '0 : DEPTH'({sr_q, d_i});
  assign q_o = sr_q[DEPTH-1];
  assign empty_o = ~|sr_q;
  // Shift one stage per clock; clear discards every in-flight ack at once
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) sr_q <= '0;
    else sr_q <= sr_d;
endmodule

// File: rtl/wb_fsm_burst.sv
// wb_fsm_burst: Wishbone B4 pipelined slave controller bridging bursts to egress/ingress FIFOs
module wb_fsm_burst
  import wb_fsm_burst_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 5
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [2:0]       cti_i,
  input  logic [1:0]       bte_i,
  input  logic             stall_i,
  output logic             stall_o,
  output logic             ack_o,
  output logic             egress_fifo_we,
  input  logic             egress_fifo_full,
  output logic             ingress_fifo_re,
  input  logic             ingress_fifo_empty,
  output logic [CNT_W-1:0] burst_len_o,
  output logic             state_idle
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, len_q, len_d, iss_q, iss_d, ackc_q, ackc_d, dec_len;
  logic req, wr_go, rd_go, eob, open_q, pipe_q, pipe_empty, clr;
  assign req = cyc_i & stb_i & ~wb_rst;
  assign eob = cti_i == CTI_EOB;
  assign open_q = len_q == '0;
  assign dec_len = CNT_W'(decode_len(cti_i, bte_i));
  assign wr_go = req & ~egress_fifo_full & ~stall_i;
  assign rd_go = req & ~ingress_fifo_empty & ~stall_i & (open_q | (iss_q < len_q));
  assign state_idle = state_q == ST_IDLE;
  wb_ack_delay #(.DEPTH(RD_LAT)) u_ack_delay (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .clr_i  (clr),
    .d_i    (ingress_fifo_re),
    .q_o    (pipe_q),
    .empty_o(pipe_empty)
  );
  // Next-state, counters and all handshake strobes; default is a stalled, silent port
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    len_d = len_q;
    iss_d = iss_q;
    ackc_d = ackc_q;
    stall_o = 1'b1;
    ack_o = 1'b0;
    egress_fifo_we = 1'b0;
    ingress_fifo_re = 1'b0;
    burst_len_o = '0;
    clr = 1'b0;
    case (state_q)
      ST_IDLE: if (wr_go) begin
        egress_fifo_we = 1'b1;
        stall_o = 1'b0;
        burst_len_o = dec_len;
        len_d = dec_len;
        rem_d = dec_len - ONE;
        iss_d = '0;
        ackc_d = '0;
        ack_o = we_i;
        state_d = !we_i ? ST_RD : dec_len == ONE ? ST_IDLE : ST_WR;
      end
      ST_WR: if (!cyc_i) state_d = ST_IDLE;
      else if (wr_go) begin
        egress_fifo_we = 1'b1;
        stall_o = 1'b0;
        ack_o = 1'b1;
        rem_d = rem_q - ONE;
        state_d = ((!open_q && rem_q == ONE) || eob) ? ST_IDLE : ST_WR;
      end
      ST_RD: if (!cyc_i) begin
        state_d = ST_FE;
        clr = 1'b1;
      end else begin
        ingress_fifo_re = rd_go;
        stall_o = ~rd_go;
        iss_d = iss_q + CNT_W'(rd_go);
        ack_o = pipe_q & stb_i;
        ackc_d = ackc_q + CNT_W'(ack_o);
        state_d = !ack_o ? ST_RD : open_q ? (eob ? ST_FE : ST_RD) :
                  ackc_q == len_q - ONE ? ST_IDLE : ST_RD;
      end
      default: begin
        ingress_fifo_re = ~ingress_fifo_empty & ~stall_i & ~wb_rst;
        state_d = (ingress_fifo_empty & pipe_empty) ? ST_IDLE : ST_FE;
      end
    endcase
  end
  // State and counter registers
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      state_q <= ST_IDLE;
      rem_q <= '0;
      len_q <= '0;
      iss_q <= '0;
      ackc_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      len_q <= len_d;
      iss_q <= iss_d;
      ackc_q <= ackc_d;
    end
endmodule

// File: tb/tb_wb_fsm_burst.sv
// tb_wb_fsm_burst: directed checks of write/read bursts, stalls, aborts and reset
module tb_wb_fsm_burst;
  logic wb_clk = 1'b0, wb_rst = 1'b1;
  logic cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, stall_i = 1'b0, egress_fifo_full = 1'b0;
  logic [2:0] cti_i = 3'b000;
  logic [1:0] bte_i = 2'b00;
  logic stall_o, ack_o, egress_fifo_we, ingress_fifo_re, ingress_fifo_empty, state_idle;
  logic [4:0] burst_len_o;
  int tests = 0, fails = 0;
  int n_we = 0, n_re = 0, n_ack = 0, viol = 0;
  int ing_cnt = 0, load_val = 0;
  logic load = 1'b0, pop_pend = 1'b0;
  int b_we, b_re, b_ack;

  wb_fsm_burst #(.RD_LAT(2), .CNT_W(5)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .cti_i(cti_i), .bte_i(bte_i), .stall_i(stall_i), .stall_o(stall_o), .ack_o(ack_o),
    .egress_fifo_we(egress_fifo_we), .egress_fifo_full(egress_fifo_full),
    .ingress_fifo_re(ingress_fifo_re), .ingress_fifo_empty(ingress_fifo_empty),
    .burst_len_o(burst_len_o), .state_idle(state_idle)
  );

  always #5 wb_clk = ~wb_clk;
  assign ingress_fifo_empty = ing_cnt == 0;

  // Ingress FIFO occupancy model: loaded by the stimulus, drained by sampled pops
  always @(posedge wb_clk) ing_cnt <= load ? load_val : ing_cnt - (pop_pend ? 1 : 0);

  // Mid-cycle monitor: strobe counts and FIFO protocol violations
  always @(negedge wb_clk) begin
    pop_pend <= ingress_fifo_re;
    n_re <= n_re + (ingress_fifo_re ? 1 : 0);
    n_we <= n_we + (egress_fifo_we ? 1 : 0);
    n_ack <= n_ack + (ack_o ? 1 : 0);
    if ((egress_fifo_we && egress_fifo_full) || (ingress_fifo_re && ingress_fifo_empty)) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] cti, input logic [1:0] bte);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; cti_i = cti; bte_i = bte;
  endtask

  task automatic idle_bus;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000; bte_i = 2'b00;
  endtask

  task automatic prefill(input int n);
    nxt;
    load_val = n;
    load = 1'b1;
    nxt;
    load = 1'b0;
  endtask

  task automatic snap;
    b_we = n_we; b_re = n_re; b_ack = n_ack;
  endtask

  initial begin
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;
    check("rst_idle", state_idle, 1);
    check("rst_stall", stall_o, 1);
    check("rst_ack", ack_o, 0);
    check("rst_we", egress_fifo_we, 0);
    check("rst_re", ingress_fifo_re, 0);
    check("rst_len", burst_len_o, 0);
    wb_rst = 1'b0;
    idle_bus;
    nxt;
    req(1'b1, 3'b000, 2'b00);
    #1;
    check("cl_we", egress_fifo_we, 1);
    check("cl_ack", ack_o, 1);
    check("cl_len", burst_len_o, 1);
    check("cl_stall", stall_o, 0);
    nxt;
    idle_bus;
    #1;
    check("cl_idle", state_idle, 1);

    nxt;
    snap;
    req(1'b1, 3'b010, 2'b10);
    #1;
    check("w8_len", burst_len_o, 8);
    check("w8_ack1", ack_o, 1);
    nxt;
    nxt;
    egress_fifo_full = 1'b1;
    #1;
    check("w8_full_stall", stall_o, 1);
    check("w8_full_ack", ack_o, 0);
    check("w8_full_we", egress_fifo_we, 0);
    nxt;
    #1;
    check("w8_full2_stall", stall_o, 1);
    nxt;
    egress_fifo_full = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      nxt;
      if (k == 8) begin
        #1;
        check("w8_last_busy", state_idle, 0);
        check("w8_last_ack", ack_o, 1);
      end
    end
    nxt;
    idle_bus;
    #1;
    check("w8_idle", state_idle, 1);
    check("w8_pushes", n_we - b_we, 8);
    check("w8_acks", n_ack - b_ack, 8);

    prefill(4);
    req(1'b0, 3'b010, 2'b01);
    #1;
    check("r4_cmd", egress_fifo_we, 1);
    check("r4_len", burst_len_o, 4);
    check("r4_cmd_ack", ack_o, 0);
    for (int k = 1; k <= 7; k++) begin
      nxt;
      if (k == 7) idle_bus;
      #1;
      check($sformatf("r4_re_c%0d", k), ingress_fifo_re, (k <= 4) ? 1 : 0);
      check($sformatf("r4_ack_c%0d", k), ack_o, (k >= 3 && k <= 6) ? 1 : 0);
      check($sformatf("r4_idle_c%0d", k), state_idle, (k == 7) ? 1 : 0);
    end

    prefill(8);
    snap;
    req(1'b0, 3'b010, 2'b00);
    #1;
    check("rl_len", burst_len_o, 0);
    check("rl_cmd", egress_fifo_we, 1);
    for (int k = 1; k <= 7; k++) begin
      nxt;
      if (k == 7) cti_i = 3'b111;
    end
    nxt;
    idle_bus;
    #1;
    check("rl_busy", state_idle, 0);
    for (int k = 0; k < 20 && !state_idle; k++) nxt;
    check("rl_idle", state_idle, 1);
    check("rl_acks", n_ack - b_ack, 5);
    check("rl_pops", n_re - b_re, 8);
    check("rl_drained", ing_cnt, 0);

    prefill(16);
    snap;
    req(1'b0, 3'b010, 2'b11);
    #1;
    check("r16_len", burst_len_o, 16);
    for (int k = 0; k < 30 && (n_ack - b_ack) < 6; k++) nxt;
    idle_bus;
    #1;
    check("r16_abort_acks", n_ack - b_ack, 6);
    check("r16_abort_ack", ack_o, 0);
    for (int k = 0; k < 40 && !state_idle; k++) nxt;
    check("r16_idle", state_idle, 1);
    check("r16_no_more_acks", n_ack - b_ack, 6);
    check("r16_pops", n_re - b_re, 16);
    check("r16_drained", ing_cnt, 0);

    nxt;
    req(1'b1, 3'b010, 2'b10);
    nxt;
    nxt;
    nxt;
    #1;
    check("rw_busy", state_idle, 0);
    #1;
    wb_rst = 1'b1;
    #1;
    check("rw_idle", state_idle, 1);
    check("rw_we", egress_fifo_we, 0);
    check("rw_ack", ack_o, 0);
    check("rw_re", ingress_fifo_re, 0);
    check("rw_stall", stall_o, 1);
    nxt;
    wb_rst = 1'b0;
    idle_bus;
    nxt;
    req(1'b1, 3'b000, 2'b00);
    #1;
    check("rw_new_ack", ack_o, 1);
    check("rw_new_we", egress_fifo_we, 1);
    check("rw_new_len", burst_len_o, 1);
    nxt;
    idle_bus;
    #1;
    check("rw_new_idle", state_idle, 1);
    nxt;
    check("fifo_protocol", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
